// File: rtl/pipe_ctrl_if.sv
// Handshake and control bundle between the 5-stage pipeline datapath and pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             hz_stall;
    logic             br_taken;
    logic             mem_access;
    logic             dmem_ready;
    logic             imem_ready;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_we;
    logic             idex_flush;
    logic             exmem_we;
    logic             memwb_we;
    logic             memwb_flush;
    logic             err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Datapath side: raises requests and memory handshakes, consumes controls.
    modport master (
        output hz_stall, br_taken, mem_access, dmem_ready, imem_ready,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
               exmem_we, memwb_we, memwb_flush, err, stall_cnt, flush_cnt
    );

    // Sequencer side.
    modport slave (
        input  hz_stall, br_taken, mem_access, dmem_ready, imem_ready,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
               exmem_we, memwb_we, memwb_flush, err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges hazard stall, branch redirect and memory wait
// into per-register write enables / flushes, with wait timeout and perf counters.
module pipe_ctrl #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {RUN, DWAIT, IWAIT, ERR} state_t;

    // Which control pattern is in force this cycle.
    typedef enum logic [2:0] {R_GO, R_BR, R_HAZ, R_IMISS, R_FREEZE, R_ERR} rule_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    rule_t             sel;
    rule_t             late_sel;
    logic              d_miss;
    logic              pc_we;
    logic              ifid_we;
    logic              ifid_flush;
    logic              idex_we;
    logic              idex_flush;
    logic              exmem_we;
    logic              memwb_we;
    logic              memwb_flush;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    assign d_miss = bus.mem_access && !bus.dmem_ready;

    // Rules 3-5: what the pipeline does once both memories are satisfied.
    always_comb begin
        late_sel = R_GO;
        if (bus.hz_stall)      late_sel = R_HAZ;
        else if (bus.br_taken) late_sel = R_BR;
    end

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next state, wait counter and rule selection.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        sel          = R_GO;
        unique case (state)
            RUN: begin
                if (d_miss) begin
                    sel          = R_FREEZE;
                    state_nxt    = DWAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end else if (!bus.imem_ready) begin
                    sel          = R_IMISS;
                    state_nxt    = IWAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end else begin
                    sel = late_sel;
                end
            end
            DWAIT: begin
                if (bus.dmem_ready) begin
                    // Fetch miss on the release cycle is re-detected from RUN next cycle.
                    sel          = bus.imem_ready ? late_sel : R_IMISS;
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    sel = R_FREEZE;
                    if (wait_cnt == WAIT_W'(MAX_WAIT)) state_nxt = ERR;
                    else wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            IWAIT: begin
                if (d_miss) begin
                    sel          = R_FREEZE;
                    state_nxt    = DWAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end else if (bus.imem_ready) begin
                    sel          = late_sel;
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    sel = R_IMISS;
                    if (wait_cnt == WAIT_W'(MAX_WAIT)) state_nxt = ERR;
                    else wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: sel = R_ERR;
        endcase
    end

    // Decode selected rule into controls; reset forces a full bubble.
    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_we     = 1'b0;
        idex_flush  = 1'b0;
        exmem_we    = 1'b0;
        memwb_we    = 1'b0;
        memwb_flush = 1'b0;
        if (!rst_n || sel == R_ERR) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            unique case (sel)
                R_FREEZE: memwb_flush = 1'b1;
                R_IMISS: begin
                    exmem_we = 1'b1;
                    memwb_we = 1'b1;
                    if (bus.hz_stall) begin
                        idex_flush = 1'b1;
                    end else begin
                        ifid_flush = 1'b1;
                        idex_we    = 1'b1;
                    end
                end
                R_HAZ: begin
                    idex_flush = 1'b1;
                    exmem_we   = 1'b1;
                    memwb_we   = 1'b1;
                end
                default: begin
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    idex_we    = 1'b1;
                    exmem_we   = 1'b1;
                    memwb_we   = 1'b1;
                    ifid_flush = (sel == R_BR);
                end
            endcase
        end
    end

    // Saturating stall / branch-flush performance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_we && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (sel == R_BR && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_we     = idex_we;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_we    = exmem_we;
    assign bus.memwb_we    = memwb_we;
    assign bus.memwb_flush = memwb_flush;
    assign bus.err         = (state == ERR);
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed plan sequences plus random traffic
// against a wait-age reference model.
module tb_pipe_ctrl;
    localparam int unsigned MAX_WAIT = 15;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned CNT_MAX  = 65535;

    // ctrl = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we, memwb_flush}
    typedef struct packed {
        logic [7:0]       ctrl;
        logic             err;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
        int               cyc;
    } exp_t;

    localparam logic [7:0] V_FREEZE = 8'b0000_0001;
    localparam logic [7:0] V_HAZ    = 8'b0000_1110;
    localparam logic [7:0] V_IMISS  = 8'b0011_0110;
    localparam logic [7:0] V_BR     = 8'b1111_0110;
    localparam logic [7:0] V_GO     = 8'b1101_0110;
    localparam logic [7:0] V_BUBBLE = 8'b0010_1001;

    logic clk = 1'b0;
    logic rst_n;
    pipe_ctrl_if #(.CNT_W(CNT_W)) bus();

    pipe_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W), .WAIT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   stim_done = 0;

    // Reference model: age of an outstanding data / fetch miss (0 = none).
    int d_age = 0;
    int i_age = 0;
    bit err_m = 0;
    int sc = 0;
    int fc = 0;

    task automatic model_step(input bit rst, input bit hz, input bit br,
                              input bit ma, input bit dr, input bit ir);
        exp_t       e;
        logic [7:0] v;
        bit         dmiss;
        bit         brc;
        dmiss = ma && !dr;
        brc   = 0;
        e.err = err_m;
        e.sc  = CNT_W'(sc);
        e.fc  = CNT_W'(fc);
        e.cyc = cyc;
        // rules 3-5 outcome when both memories are satisfied
        v = hz ? V_HAZ : (br ? V_BR : V_GO);
        if (!rst) begin
            v = V_BUBBLE;
        end else if (err_m) begin
            v = V_BUBBLE;
        end else if (d_age > 0) begin
            if (dr) begin
                if (!ir) v = hz ? V_HAZ : V_IMISS;
                d_age = 0;
            end else begin
                v = V_FREEZE;
                if (d_age == MAX_WAIT) begin err_m = 1; d_age = 0; end
                else d_age++;
            end
        end else if (i_age > 0) begin
            if (dmiss) begin
                v = V_FREEZE; i_age = 0; d_age = 1;
            end else if (ir) begin
                i_age = 0;
            end else begin
                v = hz ? V_HAZ : V_IMISS;
                if (i_age == MAX_WAIT) begin err_m = 1; i_age = 0; end
                else i_age++;
            end
        end else if (dmiss) begin
            v = V_FREEZE; d_age = 1;
        end else if (!ir) begin
            v = hz ? V_HAZ : V_IMISS; i_age = 1;
        end
        if (rst && v == V_BR) brc = 1;
        e.ctrl = v;
        exp_q.push_back(e);
        if (!rst) begin
            d_age = 0; i_age = 0; err_m = 0; sc = 0; fc = 0;
        end else begin
            if (!v[7] && sc < CNT_MAX) sc++;
            if (brc && fc < CNT_MAX) fc++;
        end
    endtask

    // Drive one cycle of inputs just after the active edge and log the expectation.
    task automatic cyc_in(input bit rst, input bit hz, input bit br,
                          input bit ma, input bit dr, input bit ir);
        @(posedge clk);
        #1;
        cyc++;
        rst_n          = rst;
        bus.hz_stall   = hz;
        bus.br_taken   = br;
        bus.mem_access = ma;
        bus.dmem_ready = dr;
        bus.imem_ready = ir;
        model_step(rst, hz, br, ma, dr, ir);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc_in(1, 0, 0, 0, 1, 1);
    endtask

    // Monitor: compare DUT outputs on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [7:0] got;
            e   = exp_q.pop_front();
            got = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_we,
                   bus.idex_flush, bus.exmem_we, bus.memwb_we, bus.memwb_flush};
            tests++;
            if (got !== e.ctrl) begin
                fails++;
                $display("FAIL ctrl cyc=%0d got=%b exp=%b", e.cyc, got, e.ctrl);
            end
            tests++;
            if (bus.err !== e.err) begin
                fails++;
                $display("FAIL err cyc=%0d got=%b exp=%b", e.cyc, bus.err, e.err);
            end
            tests++;
            if (bus.stall_cnt !== e.sc) begin
                fails++;
                $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", e.cyc, bus.stall_cnt, e.sc);
            end
            tests++;
            if (bus.flush_cnt !== e.fc) begin
                fails++;
                $display("FAIL flush_cnt cyc=%0d got=%0d exp=%0d", e.cyc, bus.flush_cnt, e.fc);
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        bus.hz_stall   = 1'b0;
        bus.br_taken   = 1'b0;
        bus.mem_access = 1'b0;
        bus.dmem_ready = 1'b1;
        bus.imem_ready = 1'b1;

        // 1: reset then free running
        cyc_in(0, 0, 0, 0, 1, 1);
        idle(10);
        // 2: one-cycle hazard stall
        cyc_in(1, 1, 0, 0, 1, 1);
        idle(1);
        // 3: branch under hazard, then branch alone
        cyc_in(1, 1, 1, 0, 1, 1);
        cyc_in(1, 0, 1, 0, 1, 1);
        idle(1);
        // 4: data miss for 3 cycles then ready
        for (int k = 0; k < 3; k++) cyc_in(1, 0, 0, 1, 0, 1);
        cyc_in(1, 0, 0, 1, 1, 1);
        idle(1);
        // 5: fetch miss with hazard, then data miss preempts from IWAIT
        cyc_in(1, 1, 0, 0, 1, 0);
        cyc_in(1, 0, 0, 1, 0, 0);
        cyc_in(1, 0, 0, 1, 1, 1);
        idle(1);
        // 6: data timeout into ERR, sticky through ready, cleared by reset
        for (int k = 0; k < 20; k++) cyc_in(1, 0, 0, 1, 0, 1);
        for (int k = 0; k < 3; k++) cyc_in(1, 0, 1, 1, 1, 1);
        cyc_in(0, 0, 0, 0, 1, 1);
        idle(2);
        // fetch-side timeout
        for (int k = 0; k < 18; k++) cyc_in(1, 0, 0, 0, 1, 0);
        cyc_in(0, 0, 0, 0, 1, 1);
        // random traffic
        for (int k = 0; k < 3000; k++) begin
            bit rst, hz, br, ma, dr, ir;
            rst = ($urandom_range(0, 199) != 0);
            hz  = ($urandom_range(0, 99) < 20);
            br  = ($urandom_range(0, 99) < 25);
            ma  = ($urandom_range(0, 99) < 40);
            dr  = ($urandom_range(0, 99) < 70);
            ir  = ($urandom_range(0, 99) < 75);
            cyc_in(rst, hz, br, ma, dr, ir);
        end
        @(posedge clk);
        @(posedge clk);
        stim_done = 1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Combines three stall/flush sources into per-register write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB:
  - the ID-stage hazard stall (load-use / branch-operand hazards);
  - ID-stage branch/jump redirect;
  - variable-latency instruction and data memory handshakes.
- Owns the memory-wait state machine, the wait timeout, and saturating performance counters for stall and flush cycles.

Parameters:
- MAX_WAIT, 15: maximum consecutive not-ready cycles tolerated in a wait state before entering ERR.
- CNT_W, 16: width of the performance counters.
- WAIT_W, 8: width of the internal wait counter. Must satisfy MAX_WAIT < 2^WAIT_W.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- hz_stall  in  1  hazard stall request from the ID-stage hazard unit (combinational).
- br_taken  in  1  branch/jump resolved taken in ID this cycle.
- mem_access  in  1  EX/MEM holds a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- imem_ready  in  1  instruction memory returns the fetch this cycle.
- pc_we  out  1  PC load enable.
- ifid_we  out  1  IF/ID load enable.
- ifid_flush  out  1  load a NOP into IF/ID (dominates ifid_we).
- idex_we  out  1  ID/EX load enable.
- idex_flush  out  1  load a bubble (control bits zero) into ID/EX.
- exmem_we  out  1  EX/MEM load enable.
- memwb_we  out  1  MEM/WB load enable.
- memwb_flush  out  1  load a bubble into MEM/WB.
- err  out  1  sticky memory-timeout error.
- stall_cnt  out  CNT_W  cycles with pc_we=0 (excluding reset cycles), saturating.
- flush_cnt  out  CNT_W  cycles with ifid_flush due to br_taken, saturating.

Behaviour:

Reset and timing:
- Reset is synchronous and active-low on clk.
- While rst_n=0, outputs are combinationally forced: all *_we=0, ifid_flush=idex_flush=memwb_flush=1.
- On a rising edge with rst_n=0: state=RUN, wait_cnt=0, err=0, stall_cnt=0, flush_cnt=0.
- Controls are Mealy: combinational from state and inputs, effective in the same cycle. Zero latency.

States: RUN, DWAIT, IWAIT, ERR. Priority in RUN, highest first:
1. mem_access && !dmem_ready: full freeze. All *_we=0, memwb_flush=1. Next state DWAIT, wait_cnt=1.
2. !imem_ready:
   - pc_we=0, exmem_we=memwb_we=1.
   - If hz_stall: ifid_we=0, idex_flush=1.
   - Else: ifid_flush=1, idex_we=1.
   - Next state IWAIT, wait_cnt=1.
3. hz_stall: pc_we=0, ifid_we=0, idex_flush=1, exmem_we=memwb_we=1.
4. br_taken: all *_we=1, ifid_flush=1; flush_cnt increments.
5. Otherwise: all *_we=1, all flushes 0.

- hz_stall dominates br_taken: the redirect is re-evaluated next cycle with resolved operands.

DWAIT:
- Outputs identical to RUN rule 1.
- On dmem_ready: apply the RUN rule evaluation (rules 2-5) this cycle, go to RUN, clear wait_cnt.
- Else if wait_cnt==MAX_WAIT: go to ERR.
- Else wait_cnt++.

IWAIT:
- A data-side miss (rule 1) preempts: go to DWAIT, wait_cnt=1.
- On imem_ready: apply rules 3-5, go to RUN.
- Else if wait_cnt==MAX_WAIT: go to ERR.
- Else wait_cnt++, outputs as rule 2.

ERR:
- All *_we=0, all flushes=1, err=1.
- Leaves only via reset.

Counters:
- stall_cnt increments in any non-reset cycle with pc_we=0, including ERR.
- Both counters saturate at 2^CNT_W-1.
- Simultaneous br_taken and stall: no flush count.

Test Plan:
1. Reset, then ready=1 and no hazards for 10 cycles.
   -> All *_we=1, flushes=0, stall_cnt=0, flush_cnt=0, err=0.
2. One-cycle hz_stall pulse.
   -> That cycle: pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1.
   -> stall_cnt=1.
3. br_taken with hz_stall=1, then br_taken alone.
   -> Cycle 1: stall behaviour, flush_cnt=0.
   -> Cycle 2: ifid_flush=1, pc_we=1, flush_cnt=1.
4. mem_access=1, dmem_ready low 3 cycles then high.
   -> 3 cycles full freeze with memwb_flush=1.
   -> 4th cycle: all we=1.
   -> stall_cnt=3, state RUN.
5. imem_ready=0 with hz_stall=1 for one cycle.
   -> pc_we=0, ifid_we=0, ifid_flush=0, idex_flush=1.
   -> Next cycle in IWAIT: mem_access&&!dmem_ready moves the block to DWAIT.
6. MAX_WAIT=15, dmem_ready held 0.
   -> ERR entered after 16 wait cycles; err=1 stays set through ready=1.
   -> Cleared only by rst_n=0 for one edge.
   -> stall_cnt continues to increment in ERR.
